// File: rtl/alu_arb_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_arb_seq
// Description : Round-robin arbiter and bit-serial sequencer for a shared
//               1-bit logic unit (AND/OR/NAND/NOR). Two requesters submit
//               WIDTH-bit operand pairs; the granted operation is evaluated
//               one bit per cycle, LSB first, and the assembled result is
//               returned on a valid/ready response port tagged with the
//               requester ID.
//               Optional feature macro: ALU_ARB_ZERO_FLAG_EN adds the
//               registered rsp_zero output (rsp_res == 0).
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arb_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [1:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [1:0]       req1_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_res,
    output logic             rsp_id,
    output logic             busy
`ifdef ALU_ARB_ZERO_FLAG_EN
    ,
    output logic             rsp_zero
`endif
);

    localparam int              c_CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

    localparam logic [1:0] c_OP_AND  = 2'b00;
    localparam logic [1:0] c_OP_OR   = 2'b01;
    localparam logic [1:0] c_OP_NAND = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic             r_rr;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [1:0]       r_op;
    logic             r_id;
    logic [c_CW-1:0]  r_cnt;
    logic [WIDTH-1:0] r_res;

    logic             w_grant0;
    logic             w_grant1;
    logic             w_accept;
    logic             w_accept_id;
    logic             w_bit;
    logic [WIDTH-1:0] w_res_nxt;
    logic             w_last;

    // Grant selection: a lone requester wins, otherwise the rr pointer decides
    always_comb begin
        w_grant0 = req0_valid & (~req1_valid | ~r_rr);
        w_grant1 = req1_valid & (~req0_valid |  r_rr);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs; ready is also held low while reset is asserted
    always_comb begin
        w_state_nxt = r_state;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        w_accept    = 1'b0;
        w_accept_id = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req0_ready = w_grant0 & rst_n;
                req1_ready = w_grant1 & rst_n;
                if (w_grant0 | w_grant1) begin
                    w_accept    = 1'b1;
                    w_accept_id = w_grant1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // One result bit from the captured operands at the current bit position
    always_comb begin
        case (r_op)
            c_OP_AND:  w_bit =   r_a[r_cnt] & r_b[r_cnt];
            c_OP_OR:   w_bit =   r_a[r_cnt] | r_b[r_cnt];
            c_OP_NAND: w_bit = ~(r_a[r_cnt] & r_b[r_cnt]);
            default:   w_bit = ~(r_a[r_cnt] | r_b[r_cnt]);
        endcase
        w_res_nxt        = r_res;
        w_res_nxt[r_cnt] = w_bit;
        w_last           = (r_cnt == c_LAST);
    end

    // Operand capture on accept, then serial result assembly during RUN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr  <= 1'b0;
            r_a   <= '0;
            r_b   <= '0;
            r_op  <= 2'b00;
            r_id  <= 1'b0;
            r_cnt <= '0;
            r_res <= '0;
        end else if (w_accept) begin
            r_a   <= w_accept_id ? req1_a  : req0_a;
            r_b   <= w_accept_id ? req1_b  : req0_b;
            r_op  <= w_accept_id ? req1_op : req0_op;
            r_id  <= w_accept_id;
            r_rr  <= ~w_accept_id;
            r_cnt <= '0;
            r_res <= '0;
        end else if (r_state == ST_RUN) begin
            r_res <= w_res_nxt;
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

`ifdef ALU_ARB_ZERO_FLAG_EN
    logic r_zero;

    // Zero flag is registered alongside the final result bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_zero <= 1'b0;
        end else if (r_state == ST_RUN && w_last) begin
            r_zero <= (w_res_nxt == '0);
        end
    end

    assign rsp_zero = r_zero;
`endif

    assign rsp_valid = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);
    assign rsp_res   = r_res;
    assign rsp_id    = r_id;

endmodule
`default_nettype wire

// File: doc/alu_arb_seq.md
# alu_arb_seq

Bit-serial sequencer and round-robin arbiter for the shared 1-bit logic unit (AND/OR/NAND/NOR). Two requesters each submit a WIDTH-bit operand pair and a 2-bit opcode. The block grants one requester at a time and drives the shared logic function one bit per cycle, LSB first. It then returns the assembled WIDTH-bit result on a valid/ready response port tagged with the requester ID.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2–32.

- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has a request
- req0_ready  out  1  requester 0 request accepted this cycle
- req0_a, req0_b  in  WIDTH  requester 0 operands
- req0_op  in  2  requester 0 opcode: 00 AND, 01 OR, 10 NAND, 11 NOR
- req1_valid / req1_ready / req1_a / req1_b / req1_op  same as requester 0, for requester 1
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_res  out  WIDTH  result
- rsp_id  out  1  requester that owns rsp_res
- busy  out  1  high in RUN or DONE
- rsp_zero  out  1  rsp_res == 0; present only with ALU_ARB_ZERO_FLAG_EN

## Operation
- FSM states: IDLE, RUN, DONE. All outputs reset to 0. State resets to IDLE, round-robin pointer `rr` to 0, and bit counter to 0.
- **IDLE**
  - Grant rules:
    - only reqN_valid high → grant N;
    - both high → grant requester `rr`;
    - none high → stay in IDLE.
  - reqN_ready = (state==IDLE) & grantN. It is combinational and one-hot or zero.
  - A request transfers when valid and ready are both high. On that edge: capture a, b, op, and id; clear the counter; set `rr` to the other requester; go to RUN.
- **RUN**
  - Each cycle computes one result bit from captured a[cnt], b[cnt] and op:
    - 00: a&b
    - 01: a|b
    - 10: ~(a&b)
    - 11: ~(a|b)
  - The bit is written into result[cnt]; cnt increments.
  - After the edge that writes bit WIDTH-1: go to DONE and set rsp_valid.
- **DONE**
  - rsp_valid=1. rsp_res and rsp_id are stable until rsp_valid & rsp_ready.
  - On that edge: rsp_valid→0, go to IDLE.
  - No requests are accepted in RUN or DONE; both req_ready are low.
- Requesters hold their inputs stable while valid and not yet accepted. Changes after acceptance have no effect.
- busy = (state != IDLE).
- A request that is not granted keeps waiting; there is no drop and no timeout.

## Timing
- Handshake edge E0. RUN occupies the WIDTH cycles after E0. rsp_valid is first high in cycle E0+WIDTH+1, i.e. latency WIDTH+1 cycles.
- With rsp_ready held high, rsp_valid lasts 1 cycle. IDLE follows, so the next accept can occur at the earliest WIDTH+2 cycles after the previous one.
- rsp_ready low stalls DONE indefinitely. Outputs hold with no corruption.
- Starvation bound: with both requesters continuously valid, grants alternate strictly 0,1,0,1,…
- rst_n low at any point, including mid-RUN or in DONE, clears everything immediately and asynchronously. The in-flight operation is discarded and no response is issued. The first grant after reset goes to requester 0 if both are valid.
- rsp_valid is never asserted without a preceding accepted request.

## Configuration
- ALU_ARB_ZERO_FLAG_EN
  - Defined: adds output rsp_zero. It is registered, updated together with the result, equal to (rsp_res==0), valid while rsp_valid, and reset to 0.
  - Undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- WIDTH=8; req0 a=0xF0 b=0xCC op=00, rsp_ready=1 → rsp_res=0xC0, rsp_id=0, rsp_valid first high 9 cycles after the accept edge for 1 cycle.
- Same operands, op=01/10/11 → rsp_res 0xFC / 0x3F / 0x03.
- Both valid from reset, 4 ops each → grant order 0,1,0,1,…; req_ready never high for both in the same cycle; busy high throughout each op.
- rsp_ready held low 5 cycles in DONE → rsp_res/rsp_id/rsp_valid stable; both req_ready low; accept resumes the cycle after the rsp handshake.
- rst_n pulsed low after 3 RUN cycles → all outputs 0 immediately; no rsp_valid. A following req1 a=0xAA b=0x55 op=11 → 0x00, rsp_id=1.
- ALU_ARB_ZERO_FLAG_EN defined: a=0x0F b=0xF0 op=00 → rsp_res=0x00, rsp_zero=1. Then op=01 → rsp_res=0xFF, rsp_zero=0.
